// File: rtl/autoconfig_zii_pkg.sv
// rtl/autoconfig_zii_pkg.sv - shared constants and types for the multi-board Zorro II AutoConfig engine
package autoconfig_zii_pkg;

    localparam logic [7:0] E8_REGION       = 8'hE8;

    localparam logic [5:0] ER_TYPE_HI      = 6'h00;
    localparam logic [5:0] ER_TYPE_LO      = 6'h01;
    localparam logic [5:0] ER_PROD_HI      = 6'h02;
    localparam logic [5:0] ER_PROD_LO      = 6'h03;
    localparam logic [5:0] ER_FLAGS_HI     = 6'h04;
    localparam logic [5:0] ER_FLAGS_LO     = 6'h05;
    localparam logic [5:0] ER_MFG_FIRST    = 6'h08;
    localparam logic [5:0] ER_MFG_LAST     = 6'h0B;
    localparam logic [5:0] ER_SERIAL_FIRST = 6'h0C;
    localparam logic [5:0] ER_SERIAL_LAST  = 6'h13;
    localparam logic [5:0] ER_ROMV_FIRST   = 6'h14;
    localparam logic [5:0] ER_ROMV_LAST    = 6'h17;
    localparam logic [5:0] ER_ZERO_HI      = 6'h20;
    localparam logic [5:0] ER_ZERO_LO      = 6'h21;
    localparam logic [5:0] ER_BASE_HI      = 6'h24;
    localparam logic [5:0] ER_BASE_LO      = 6'h25;
    localparam logic [5:0] ER_SHUTUP       = 6'h26;

    typedef enum logic [1:0] {
        UNCFG      = 2'd0,
        CONFIGURED = 2'd1,
        SHUTUP     = 2'd2
    } board_state_e;

endpackage

// File: rtl/autoconfig_zii_rom.sv
// rtl/autoconfig_zii_rom.sv - combinational AutoConfig nibble lookup for the selected board
module autoconfig_zii_rom
    import autoconfig_zii_pkg::*;
#(
    parameter logic [15:0] MFG_ID = 16'h144A,
    parameter logic [31:0] SERIAL = 32'd0
) (
    input  logic [7:0]  prod_id,
    input  logic [7:0]  er_type,
    input  logic [7:0]  er_type_alt,
    input  logic [7:0]  er_flags,
    input  logic [15:0] rom_vector,
    input  logic        size_sel,
    input  logic [5:0]  a_low,
    output logic [3:0]  nibble
);

    logic [7:0] type_byte;
    logic [2:0] ser_off;

    always_comb begin
        type_byte = size_sel ? er_type_alt : er_type;
        // serial starts at 0x0C, so bias the low bits to get a 0..7 nibble offset
        ser_off   = a_low[2:0] + 3'd4;
        nibble    = 4'hF;
        if (a_low == ER_TYPE_HI) begin
            nibble = type_byte[7:4];
        end else if (a_low == ER_TYPE_LO) begin
            nibble = type_byte[3:0];
        end else if (a_low == ER_PROD_HI) begin
            nibble = ~prod_id[7:4];
        end else if (a_low == ER_PROD_LO) begin
            nibble = ~prod_id[3:0];
        end else if (a_low == ER_FLAGS_HI) begin
            nibble = ~er_flags[7:4];
        end else if (a_low == ER_FLAGS_LO) begin
            nibble = ~er_flags[3:0];
        end else if (a_low >= ER_MFG_FIRST && a_low <= ER_MFG_LAST) begin
            nibble = ~MFG_ID[{~a_low[1:0], 2'b00} +: 4];
        end else if (a_low >= ER_SERIAL_FIRST && a_low <= ER_SERIAL_LAST) begin
            nibble = ~SERIAL[{~ser_off, 2'b00} +: 4];
        end else if (a_low >= ER_ROMV_FIRST && a_low <= ER_ROMV_LAST) begin
            nibble = type_byte[4] ? ~rom_vector[{~a_low[1:0], 2'b00} +: 4] : 4'hF;
        end else if (a_low == ER_ZERO_HI || a_low == ER_ZERO_LO) begin
            nibble = 4'h0;
        end
    end

endmodule

// File: rtl/autoconfig_zii_multi.sv
// rtl/autoconfig_zii_multi.sv - Zorro II AutoConfig engine presenting NUM_BOARDS boards in sequence
module autoconfig_zii_multi
    import autoconfig_zii_pkg::*;
#(
    parameter int                       NUM_BOARDS  = 2,
    parameter logic [15:0]              MFG_ID      = 16'h144A,
    parameter logic [31:0]              SERIAL      = 32'd0,
    parameter logic [8*NUM_BOARDS-1:0]  PROD_IDS    = {8'd11, 8'd10},
    parameter logic [8*NUM_BOARDS-1:0]  ER_TYPE     = {8'hD1, 8'hE7},
    parameter logic [8*NUM_BOARDS-1:0]  ER_TYPE_ALT = {8'hD1, 8'hE0},
    parameter logic [8*NUM_BOARDS-1:0]  ER_FLAGS    = {8'hC0, 8'hC0},
    parameter logic [16*NUM_BOARDS-1:0] ROM_VECTORS = {16'h0001, 16'h0000}
) (
    input  logic                      C7M,
    input  logic                      RESET,
    input  logic                      CFGIN_n,
    input  logic                      AS_CPU_n,
    input  logic                      DS_n,
    input  logic                      RW_n,
    input  logic [7:0]                A_HIGH,
    input  logic [5:0]                A_LOW,
    input  logic [3:0]                D_IN,
    input  logic [NUM_BOARDS-1:0]     SIZE_SEL,
    output logic [3:0]                DATA_OUT,
    output logic                      DATA_OE,
    output logic [8*NUM_BOARDS-1:0]   BASE,
    output logic [NUM_BOARDS-1:0]     CONFIGURED_n,
    output logic                      CFGOUT_n,
    output logic [1:0]                CUR_BOARD
);

    localparam logic [1:0] LAST_BOARD = 2'(NUM_BOARDS - 1);

    logic [3:0]              data_out_d, data_out_q;
    logic [8*NUM_BOARDS-1:0] base_d, base_q;
    logic [NUM_BOARDS-1:0]   cfg_n_d, cfg_n_q;
    logic                    cfgout_n_d, cfgout_n_q;
    logic [1:0]              cur_d, cur_q;
    logic [3:0]              stage_d, stage_q;
    logic                    done_cycle_d, done_cycle_q;
    logic                    advance_pend_d, advance_pend_q;
    board_state_e            state_d [NUM_BOARDS];
    board_state_e            state_q [NUM_BOARDS];

    logic        acc, rd_en, wr_en, cur_uncfg;
    logic [7:0]  sel_prod, sel_type, sel_type_alt, sel_flags;
    logic [15:0] sel_romv;
    logic        sel_size;
    logic [3:0]  rom_nibble;

    always_comb begin
        sel_prod     = '0;
        sel_type     = '0;
        sel_type_alt = '0;
        sel_flags    = '0;
        sel_romv     = '0;
        sel_size     = 1'b0;
        cur_uncfg    = 1'b0;
        for (int i = 0; i < NUM_BOARDS; i++) begin
            if (cur_q == 2'(i)) begin
                sel_prod     = PROD_IDS[8*i +: 8];
                sel_type     = ER_TYPE[8*i +: 8];
                sel_type_alt = ER_TYPE_ALT[8*i +: 8];
                sel_flags    = ER_FLAGS[8*i +: 8];
                sel_romv     = ROM_VECTORS[16*i +: 16];
                sel_size     = SIZE_SEL[i];
                cur_uncfg    = (state_q[i] == UNCFG);
            end
        end
    end

    autoconfig_zii_rom #(
        .MFG_ID (MFG_ID),
        .SERIAL (SERIAL)
    ) u_rom (
        .prod_id     (sel_prod),
        .er_type     (sel_type),
        .er_type_alt (sel_type_alt),
        .er_flags    (sel_flags),
        .rom_vector  (sel_romv),
        .size_sel    (sel_size),
        .a_low       (A_LOW),
        .nibble      (rom_nibble)
    );

    always_comb begin
        acc   = !CFGIN_n && cfgout_n_q && (A_HIGH == E8_REGION) && !AS_CPU_n && !DS_n;
        rd_en = acc && RW_n;
        wr_en = acc && !RW_n && !done_cycle_q;

        data_out_d     = data_out_q;
        base_d         = base_q;
        cfg_n_d        = cfg_n_q;
        cfgout_n_d     = cfgout_n_q;
        cur_d          = cur_q;
        stage_d        = stage_q;
        done_cycle_d   = done_cycle_q;
        advance_pend_d = advance_pend_q;
        state_d        = state_q;

        if (rd_en) begin
            data_out_d = rom_nibble;
        end

        // the board switch waits for the bus cycle to end so the committing cycle sees a stable board
        if (AS_CPU_n) begin
            done_cycle_d = 1'b0;
            if (advance_pend_q) begin
                advance_pend_d = 1'b0;
                stage_d        = 4'h0;
                if (cur_q == LAST_BOARD) begin
                    cfgout_n_d = 1'b0;
                end else begin
                    cur_d = cur_q + 2'd1;
                end
            end
        end

        if (wr_en) begin
            done_cycle_d = 1'b1;
            case (A_LOW)
                ER_BASE_LO: stage_d = D_IN;
                ER_BASE_HI, ER_SHUTUP: begin
                    advance_pend_d = advance_pend_q || cur_uncfg;
                    for (int i = 0; i < NUM_BOARDS; i++) begin
                        if (cur_q == 2'(i) && state_q[i] == UNCFG) begin
                            if (A_LOW == ER_BASE_HI) begin
                                base_d[8*i +: 8] = {D_IN, stage_q};
                                cfg_n_d[i]       = 1'b0;
                                state_d[i]       = CONFIGURED;
                            end else begin
                                state_d[i] = SHUTUP;
                            end
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge C7M) begin
        if (RESET) begin
            data_out_q     <= 4'hF;
            base_q         <= '0;
            cfg_n_q        <= '1;
            cfgout_n_q     <= 1'b1;
            cur_q          <= 2'd0;
            stage_q        <= 4'h0;
            done_cycle_q   <= 1'b0;
            advance_pend_q <= 1'b0;
            for (int i = 0; i < NUM_BOARDS; i++) begin
                state_q[i] <= UNCFG;
            end
        end else begin
            data_out_q     <= data_out_d;
            base_q         <= base_d;
            cfg_n_q        <= cfg_n_d;
            cfgout_n_q     <= cfgout_n_d;
            cur_q          <= cur_d;
            stage_q        <= stage_d;
            done_cycle_q   <= done_cycle_d;
            advance_pend_q <= advance_pend_d;
            state_q        <= state_d;
        end
    end

    assign DATA_OUT     = data_out_q;
    assign DATA_OE      = rd_en;
    assign BASE         = base_q;
    assign CONFIGURED_n = cfg_n_q;
    assign CFGOUT_n     = cfgout_n_q;
    assign CUR_BOARD    = cur_q;

endmodule
